// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store stage: bus access FSM with alignment check, lane steering and timeout
module mem_access_unit #(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [3:0]        mem_op,
    input  logic [31:0]       ex_out,
    input  logic [31:0]       ex_wr_data,
    input  logic [31:0]       bus_rd_data,
    input  logic              bus_rdy_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wr_data,
    output logic [31:0]       out,
    output logic              stall,
    output logic              miss_align,
    output logic              bus_err
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               as_q;
    logic               rw_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [31:0]        result_q;
    logic               err_q;
    logic [7:0]         cnt_q;
    logic [3:0]         op_q;
    logic [1:0]         off_q;

    logic               is_word;
    logic               is_half;
    logic               is_byte;
    logic               is_load;
    logic               is_access;
    logic               mis;
    logic [3:0]         be_d;
    logic [31:0]        wdata_d;

    function automatic logic [31:0] fmt_load(input logic [3:0] op, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [15:0] h;
        logic [7:0]  b;
        h = off[1] ? d[31:16] : d[15:0];
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        case (op)
            OP_LW:   fmt_load = d;
            OP_LH:   fmt_load = {{16{h[15]}}, h};
            OP_LHU:  fmt_load = {16'h0000, h};
            OP_LB:   fmt_load = {{24{b[7]}}, b};
            OP_LBU:  fmt_load = {24'h000000, b};
            default: fmt_load = 32'h0;
        endcase
    endfunction

    always_comb begin
        is_word   = (mem_op == OP_LW) || (mem_op == OP_SW);
        is_half   = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
        is_byte   = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
        is_load   = (mem_op >= OP_LW) && (mem_op <= OP_LBU);
        is_access = is_word || is_half || is_byte;
        mis       = (is_word && (ex_out[1:0] != 2'b00)) || (is_half && ex_out[0]);
        be_d      = 4'b1111;
        wdata_d   = ex_wr_data;
        if (is_half) begin
            be_d    = ex_out[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{ex_wr_data[15:0]}};
        end else if (is_byte) begin
            be_d    = 4'b0001 << ex_out[1:0];
            wdata_d = {4{ex_wr_data[7:0]}};
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= S_IDLE;
            as_q     <= 1'b1;
            rw_q     <= 1'b1;
            be_q     <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            result_q <= 32'h0;
            err_q    <= 1'b0;
            cnt_q    <= 8'h00;
            op_q     <= 4'h0;
            off_q    <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    err_q <= 1'b0;
                    if (is_access && !mis) begin
                        state_q <= S_BUSY;
                        as_q    <= 1'b0;
                        addr_q  <= ex_out[ADDR_W+1:2];
                        rw_q    <= is_load;
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        op_q    <= mem_op;
                        off_q   <= ex_out[1:0];
                        cnt_q   <= 8'h00;
                    end
                end
                S_BUSY: begin
                    // ready takes priority over an expiring timeout in the same cycle
                    if (!bus_rdy_) begin
                        result_q <= fmt_load(op_q, off_q, bus_rd_data);
                        err_q    <= 1'b0;
                        as_q     <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q <= 32'h0;
                        err_q    <= 1'b1;
                        as_q     <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    as_q    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        out        = 32'h0;
        stall      = 1'b0;
        miss_align = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_access && mis) begin
                    miss_align = 1'b1;
                end else if (is_access) begin
                    stall = 1'b1;
                    out   = ex_out;
                end else begin
                    out = ex_out;
                end
            end
            S_BUSY:  stall = 1'b1;
            S_DONE:  out = result_q;
            default: out = 32'h0;
        endcase
    end

    assign bus_err     = (state_q == S_DONE) && err_q;
    assign bus_addr    = addr_q;
    assign bus_as_     = as_q;
    assign bus_rw      = rw_q;
    assign bus_be      = be_q;
    assign bus_wr_data = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        reset_;
    logic [3:0]  mem_op;
    logic [31:0] ex_out;
    logic [31:0] ex_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [3:0]  bus_be;
    logic [31:0] bus_wr_data;
    logic [31:0] out;
    logic        stall;
    logic        miss_align;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int stall_cycles;

    mem_access_unit #(.ADDR_W(30), .TIMEOUT(4)) dut (
        .clk         (clk),
        .reset_      (reset_),
        .mem_op      (mem_op),
        .ex_out      (ex_out),
        .ex_wr_data  (ex_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_be      (bus_be),
        .bus_wr_data (bus_wr_data),
        .out         (out),
        .stall       (stall),
        .miss_align  (miss_align),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // apply inputs just after a rising edge, return at the following falling edge
    task automatic step(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic rdy);
        @(posedge clk);
        #1;
        mem_op      = op;
        ex_out      = addr;
        ex_wr_data  = wd;
        bus_rd_data = rd;
        bus_rdy_    = rdy;
        @(negedge clk);
    endtask

    initial begin
        reset_      = 1'b0;
        mem_op      = 4'd0;
        ex_out      = 32'h0;
        ex_wr_data  = 32'h0;
        bus_rd_data = 32'h0;
        bus_rdy_    = 1'b1;
        @(negedge clk);
        check("rst_as", 32'(bus_as_), 32'd1);
        check("rst_rw", 32'(bus_rw), 32'd1);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_wd", bus_wr_data, 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 reset_ = 1'b1;

        // LB at 0x103, ready on first BUSY cycle
        stall_cycles = 0;
        step(4'd4, 32'h103, 32'h0, 32'h80FF_0000, 1'b0);
        stall_cycles += int'(stall);
        check("lb_idle_stall", 32'(stall), 32'd1);
        check("lb_idle_as", 32'(bus_as_), 32'd1);
        step(4'd0, 32'h103, 32'h0, 32'h80FF_0000, 1'b0);
        stall_cycles += int'(stall);
        check("lb_as", 32'(bus_as_), 32'd0);
        check("lb_be", 32'(bus_be), 32'b1000);
        check("lb_addr", 32'(bus_addr), 32'h40);
        check("lb_rw", 32'(bus_rw), 32'd1);
        step(4'd0, 32'h103, 32'h0, 32'h0, 1'b1);
        stall_cycles += int'(stall);
        check("lb_out", out, 32'hFFFF_FF80);
        check("lb_done_as", 32'(bus_as_), 32'd1);
        check("lb_done_err", 32'(bus_err), 32'd0);
        check("lb_stall_cycles", 32'(stall_cycles), 32'd2);

        // LHU at 0x202
        step(4'd3, 32'h202, 32'h0, 32'h9ABC_1234, 1'b0);
        step(4'd3, 32'h202, 32'h0, 32'h9ABC_1234, 1'b0);
        check("lhu_be", 32'(bus_be), 32'b1100);
        check("lhu_addr", 32'(bus_addr), 32'h80);
        step(4'd3, 32'h202, 32'h0, 32'h0, 1'b1);
        check("lhu_out", out, 32'h0000_9ABC);
        check("lhu_done_stall", 32'(stall), 32'd0);

        // SH at 0x10
        step(4'd7, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        step(4'd0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        check("sh_rw", 32'(bus_rw), 32'd0);
        check("sh_be", 32'(bus_be), 32'b0011);
        check("sh_wd", bus_wr_data, 32'hBEEF_BEEF);
        step(4'd0, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b1);
        check("sh_out", out, 32'h0);

        // SB at 0x1: byte lane replication
        step(4'd8, 32'h1, 32'h0000_00A5, 32'h0, 1'b0);
        step(4'd0, 32'h1, 32'h0, 32'h0, 1'b0);
        check("sb_be", 32'(bus_be), 32'b0010);
        check("sb_wd", bus_wr_data, 32'hA5A5_A5A5);
        step(4'd0, 32'h1, 32'h0, 32'h0, 1'b1);

        // misaligned LW, then NOP pass-through
        step(4'd1, 32'h6, 32'h0, 32'h0, 1'b0);
        check("mis_flag", 32'(miss_align), 32'd1);
        check("mis_stall", 32'(stall), 32'd0);
        check("mis_out", out, 32'h0);
        step(4'd1, 32'h6, 32'h0, 32'h0, 1'b0);
        check("mis_as", 32'(bus_as_), 32'd1);
        step(4'd0, 32'h55, 32'h0, 32'h0, 1'b1);
        check("nop_out", out, 32'h55);
        check("nop_mis", 32'(miss_align), 32'd0);

        // LW timeout with TIMEOUT=4
        step(4'd1, 32'h20, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(4'd0, 32'h20, 32'h0, 32'h0, 1'b1);
            check($sformatf("to_busy%0d_as", i), 32'(bus_as_), 32'd0);
            check($sformatf("to_busy%0d_err", i), 32'(bus_err), 32'd0);
        end
        step(4'd0, 32'h20, 32'h0, 32'h0, 1'b1);
        check("to_err", 32'(bus_err), 32'd1);
        check("to_out", out, 32'h0);
        check("to_as", 32'(bus_as_), 32'd1);
        step(4'd0, 32'h20, 32'h0, 32'h0, 1'b1);
        check("to_idle_err", 32'(bus_err), 32'd0);

        // ready arrives in the same cycle the counter expires
        step(4'd1, 32'h24, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'd0, 32'h24, 32'h0, 32'h0, 1'b1);
        step(4'd0, 32'h24, 32'h0, 32'h1234_5678, 1'b0);
        check("exp_rdy_as", 32'(bus_as_), 32'd0);
        step(4'd0, 32'h24, 32'h0, 32'h0, 1'b1);
        check("exp_rdy_err", 32'(bus_err), 32'd0);
        check("exp_rdy_out", out, 32'h1234_5678);

        // reset pulsed during BUSY
        step(4'd6, 32'h40, 32'h1122_3344, 32'h0, 1'b1);
        step(4'd0, 32'h40, 32'h0, 32'h0, 1'b1);
        check("rb_as_busy", 32'(bus_as_), 32'd0);
        #1 reset_ = 1'b0;
        #1;
        check("rb_as_async", 32'(bus_as_), 32'd1);
        check("rb_be_async", 32'(bus_be), 32'd0);
        check("rb_rw_async", 32'(bus_rw), 32'd1);
        @(posedge clk);
        #1;
        mem_op = 4'd0;
        ex_out = 32'h77;
        reset_ = 1'b1;
        @(negedge clk);
        check("rb_idle_stall", 32'(stall), 32'd0);
        check("rb_idle_out", out, 32'h77);
        step(4'd0, 32'h77, 32'h0, 32'h0, 1'b1);
        check("rb_no_done_out", out, 32'h77);
        check("rb_no_done_as", 32'(bus_as_), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
